// File: rtl/wrr_arbiter4_pkg.sv
// Shared types and constants for the 4-way weighted round-robin arbiter.
package wrr_arb_pkg;

   localparam int N     = 4;
   localparam int CNT_W = 4;

   // Arbiter FSM: IDLE = no grant outstanding, GRANT = one owner holds the resource.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Per-requester weight registers; a weight of 0 masks that requester.
   typedef logic [CNT_W-1:0] weight_arr_t [N];

   // One-hot vector with only bit idx set.
   function automatic logic [N-1:0] idx_to_onehot(input logic [1:0] idx);
      logic [N-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wrr_arbiter4_if.sv
// Request/grant and weight-configuration bundle for wrr_arbiter4.
//
// Handshake: req[i] is a level request; the arbiter answers with a registered,
// one-hot gnt. A requester owns the resource in every cycle where gnt[i]=1 and
// keeps ownership only while it holds req[i]. Dropping req[i] releases the
// grant at the next edge. There is no separate ready; gnt is the acceptance.
// cfg_we is a single-cycle write strobe with no back-pressure.
interface wrr_arbiter4_if;
   import wrr_arb_pkg::*;

   logic             ena;
   logic [N-1:0]     req;
   logic             cfg_we;
   logic [1:0]       cfg_idx;
   logic [CNT_W-1:0] cfg_weight;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [1:0]       gnt_id;
   state_t           dbg_state;

   // Arbiter side
   modport slave (
      input  ena, req, cfg_we, cfg_idx, cfg_weight,
      output gnt, gnt_valid, gnt_id, dbg_state
   );

   // Requester / configuration side
   modport master (
      output ena, req, cfg_we, cfg_idx, cfg_weight,
      input  gnt, gnt_valid, gnt_id, dbg_state
   );

endinterface

// File: rtl/wrr_arbiter4_rr_priority_pick.sv
// Rotating priority encoder: first eligible index scanning ptr, ptr+1, ... mod N.
module rr_priority_pick
   import wrr_arb_pkg::*;
(
   input  logic [N-1:0] eligible,
   input  logic [1:0]   ptr,
   output logic         any,
   output logic [1:0]   idx
);

   logic [1:0] cand;

   // Scan offsets from farthest to nearest so the nearest eligible index wins.
   always_comb begin
      any  = 1'b0;
      idx  = 2'd0;
      cand = 2'd0;
      for (int k = N-1; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (eligible[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/wrr_arbiter4.sv
// Weighted round-robin arbiter with burst hold for four requesters.
// The owner keeps the grant for up to weight[owner] consecutive cycles, then
// rotation moves on. Grant outputs are registered and always one-hot or zero.
module wrr_arbiter4 #(
   parameter int N              = 4,
   parameter int CNT_W          = 4,
   parameter int DEFAULT_WEIGHT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   wrr_arbiter4_if.slave   bus
);
   import wrr_arb_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] W_RST   = CNT_W'(DEFAULT_WEIGHT);

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   weight_arr_t      weight_q;

   logic [N-1:0]     eligible;
   logic             pick_any;
   logic [1:0]       pick_idx;
   logic             burst_end;

   // A requester competes only while it asks and has a non-zero weight.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         eligible[i] = bus.req[i] && (weight_q[i] != '0);
      end
   end

   rr_priority_pick u_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .any      (pick_any),
      .idx      (pick_idx)
   );

   // Burst ends on request drop, quota used up (also after a weight lowered
   // below the running count or written to 0), or arbiter disable.
   always_comb begin
      burst_end = !bus.req[gnt_id_q]
               || (burst_cnt_q >= weight_q[gnt_id_q])
               || !bus.ena;
   end

   // Next-state, grant and burst-counter decisions.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      ptr_d       = ptr_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.ena && pick_any) begin
               state_d     = GRANT;
               gnt_d       = idx_to_onehot(pick_idx);
               gnt_id_d    = pick_idx;
               ptr_d       = pick_idx + 2'd1;
               burst_cnt_d = CNT_W'(1);
            end
         end
         GRANT: begin
            if (!burst_end) begin
               if (burst_cnt_q != CNT_MAX) begin
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
               end
            end else if (bus.ena && pick_any) begin
               // Handover in the same edge; the sole eligible owner re-grants itself.
               gnt_d       = idx_to_onehot(pick_idx);
               gnt_id_d    = pick_idx;
               ptr_d       = pick_idx + 2'd1;
               burst_cnt_d = CNT_W'(1);
            end else begin
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_id_d    = 2'd0;
               burst_cnt_d = '0;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_id_d    = 2'd0;
            burst_cnt_d = '0;
         end
      endcase
   end

   // FSM, grant and rotation registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= 2'd0;
         ptr_q       <= 2'd0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Weight registers; writes land regardless of ena.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            weight_q[i] <= W_RST;
         end
      end else if (bus.cfg_we) begin
         weight_q[bus.cfg_idx] <= bus.cfg_weight;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = (state_q == GRANT);
   assign bus.gnt_id    = gnt_id_q;
   assign bus.dbg_state = state_q;

endmodule

// File: doc/wrr_arbiter4.md
# wrr_arbiter4

Weighted round-robin arbiter with burst hold for four requesters sharing one resource. It is the scheduling core behind the 4-way arbiter tile. Each requester can hold a grant for up to a programmable number of consecutive cycles (its weight). Rotation then moves to the next requester. Grants are registered, one-hot and glitch-free, so the shared datapath mux can use them directly.

## Interface
Parameters:
- N, 4, number of requesters (fixed at 4 in this tile)
- CNT_W, 4, width of weight and burst counter
- DEFAULT_WEIGHT, 1, weight loaded into every slot at reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  arbiter enable; 0 forces idle
- req  in  N  request vector, level-sensitive
- cfg_we  in  1  weight write strobe
- cfg_idx  in  2  requester index for weight write
- cfg_weight  in  CNT_W  weight value; 0 masks that requester
- gnt  out  N  one-hot grant, registered
- gnt_valid  out  1  OR of gnt
- gnt_id  out  2  binary index of current owner; 0 when idle

## Operation
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, ptr=0, burst_cnt=0, state=IDLE, all weights=DEFAULT_WEIGHT.
- Eligible requester: req[i]=1 and weight[i]!=0.
- Priority pick: first eligible index scanning ptr, ptr+1, … mod N.
- IDLE state:
  - If ena=1 and any requester is eligible, the winner is granted at the next edge.
  - On that grant: burst_cnt=1, ptr=winner+1 mod N, state=GRANT.
- GRANT state: the burst ends at an edge when any of these holds:
  - req[owner]=0
  - burst_cnt==weight[owner]
  - ena=0
- At burst end:
  - ena=0: go to IDLE with gnt=0.
  - Otherwise the next winner is granted at the same edge, with no idle bubble.
  - If the owner is the only eligible requester and its burst expired, it is re-granted. gnt stays high and burst_cnt reloads to 1.
  - If nothing is eligible, go to IDLE with gnt=0.
- While the burst continues: burst_cnt increments, saturating at 2^CNT_W-1.
- Weight writes:
  - A write with cfg_we=1 updates weight[cfg_idx] at the edge.
  - The comparison always uses the current weight register. Lowering the owner's weight below burst_cnt ends the burst at the next edge.
  - Writing 0 to the owner ends its burst at the next edge.
- ena=0 preserves ptr and weights.

## Timing
- Request-to-grant latency is 1 cycle. req sampled at edge k gives gnt at edge k.
- A requester holding req continuously gets exactly weight[i] consecutive grant cycles per turn when others are waiting.
- A req drop sampled at edge k removes gnt at edge k, so the owner sees at most the current cycle of grant after dropping.
- Handover is 0 bubble cycles: gnt changes one-hot to one-hot in a single edge and is never multi-hot.
- Asynchronous reset mid-burst: gnt=0 immediately, and rotation restarts at index 0.

## Structure
- Package wrr_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - localparams N and CNT_W
  - the weight array typedef
- Sub-module rr_priority_pick is a combinational rotating priority encoder.
  - Inputs: eligible[N], ptr[1:0].
  - Outputs: any, idx[1:0].
- The top module holds the FSM, burst counter, weight registers and output registers.

## Test plan
- Reset, req=4'b1000, weights=1 → gnt=4'b1000 one cycle after req; gnt_id=3; held while req stays high.
- Weights 1, req=4'b0101 held → gnt alternates 0001, 0100, 0001 every cycle; gnt_valid stays 1.
- Weights {w0=3,w1=1,w2=2,w3=1}, req=4'b1111 → repeating pattern 0001×3, 0010×1, 0100×2, 1000×1.
- Write weight[2]=0, req=4'b0100 → gnt stays 0. Then write weight[2]=2 → gnt=4'b0100 on the edge after the write.
- Owner 1 with weight 4 drops req after 2 grant cycles while req0 is pending → gnt=4'b0001 at the edge sampling the drop; no gap cycle.
- Mid-burst: ena=0 → gnt=0 next edge. Re-enable → winner from preserved ptr. Assert rst_n=0 mid-burst → gnt=0 asynchronously and ptr=0.
